nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Sequential add/subtract engine that feeds the team's 4-bit carry-lookahead adder one nibble per clock. It handles WIDTH-bit operands, least-significant nibble first, and carries between nibbles in a register. Upstream control logic sits in front of it behind a valid/ready handshake. Downstream logic consumes the registered result and flags through a second valid/ready handshake. It trades latency for area against a fully parallel WIDTH-bit adder.

## Interface
Parameters:
- WIDTH, 8, operand/result width; multiple of 4, ≥ 4; NIB = WIDTH/4.

Ports (clock and reset first):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and op presented.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0 = A+B, 1 = A−B (A + ~B + 1).
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  sum/difference, registered.
- carry_out  out  1  final carry; for subtract, 1 = no borrow.
- overflow  out  1  signed overflow.
- zero  out  1  result == 0.

## Operation
- FSM states: IDLE → RUN → DONE → IDLE.
- **IDLE**
  - in_ready = 1.
  - On in_valid & in_ready: latch a; latch b XOR {WIDTH{sub}}; set carry register to sub; clear nibble counter and result register; go to RUN.
- **RUN**
  - Each cycle, the adder gets a_lat[4n+3:4n], b_lat[4n+3:4n] and the carry register, where n = counter.
  - Its sum is written to result[4n+3:4n]; its carry out goes to the carry register; the counter increments.
  - When n == NIB−1, go to DONE and register the flags.
- **Flags** (registered on the last-nibble edge)
  - carry_out = final nibble carry.
  - overflow = (a_lat[MSB] == b_lat[MSB]) & (sum[MSB] != a_lat[MSB]).
  - zero = all result nibbles, including the last one, equal 0.
- **DONE**
  - out_valid = 1.
  - result and flags are held stable until out_ready; on out_valid & out_ready go to IDLE.
- Inputs are ignored whenever in_ready = 0; no input is queued.
- Arithmetic is modulo 2^WIDTH; the counter width is clog2(NIB), minimum 1.

## Timing
- Reset values:
  - state = IDLE, so in_ready = 1 once rst_n is high.
  - out_valid = 0; result = 0; carry_out = 0; overflow = 0; zero = 0.
- Latency: input accepted at edge k → out_valid high after edge k+NIB (2 cycles for WIDTH = 8).
- Throughput with out_ready held high: one operation every NIB+2 cycles (the DONE cycle and the IDLE cycle are each one cycle).
- out_valid and in_ready are never high together.
- out_valid drops on the edge after the output handshake.
- Reset mid-operation (RUN or DONE): the in-flight operation is discarded and all outputs return to their reset values immediately.
- in_valid held during DONE is not accepted until the cycle after the state returns to IDLE.

## Configuration
- Macro: NIBBLE_SERIAL_ADDER_FLAGS_EN.
- Defined: overflow and zero are computed and registered as specified.
- Not defined: overflow and zero are tied to 0, their logic is removed, and the ports remain. carry_out and result are unaffected.

## Structure
- Shared package nibble_serial_adder_pkg holds:
  - the state enum typedef (IDLE, RUN, DONE);
  - the NIBBLE_W = 4 constant.
- One sub-module: cla_4bit, instantiated once as the nibble datapath. No other hierarchy.

## Test plan
All scenarios use WIDTH = 8.
- Add 0x3C + 0x45, sub = 0 → result 0x81, carry_out 0, overflow 1, zero 0; out_valid exactly 2 cycles after accept.
- Subtract 0x50 − 0x50 → result 0x00, carry_out 1, zero 1, overflow 0.
- Add 0xFF + 0x01 → result 0x00, carry_out 1, zero 1, overflow 0; checks the inter-nibble carry register.
- Subtract 0x80 − 0x01 → result 0x7F, carry_out 1, overflow 1.
- Backpressure: out_ready low for 5 cycles in DONE while in_valid toggles with new operands → result and flags unchanged, in_ready 0, no new operation accepted; the next op is accepted only after the output handshake.
- Assert rst_n low in RUN after the first nibble → all outputs at reset values during reset, in_ready 1 after release; then 0x12 + 0x34 → 0x46, carry_out 0.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial add/subtract engine.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for NIB nibbles; never narrower than one bit.
    function automatic int cnt_width(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead adder; all four carries are formed from generate/propagate terms in parallel.
module cla_4bit
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_a,
    input  logic [NIBBLE_W-1:0] i_b,
    input  logic                i_cin,
    output logic [NIBBLE_W-1:0] o_sum,
    output logic                o_cout
);

    logic [NIBBLE_W-1:0] w_g;
    logic [NIBBLE_W-1:0] w_p;
    logic [NIBBLE_W:0]   w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

    assign o_sum  = w_p ^ w_c[NIBBLE_W-1:0];
    assign o_cout = w_c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/subtract computed one nibble per clock through a single cla_4bit.
// Define NIBBLE_SERIAL_ADDER_FLAGS_EN to build the overflow and zero flags; otherwise they read 0.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output state_t           o_dbg_state
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = cnt_width(NIB);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIB - 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE, so they are never high together.

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry_out;

    logic               w_accept;
    logic               w_run;
    logic               w_last;
    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_sum;
    logic               w_cout;
    logic [WIDTH-1:0]   w_result_next;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (in_valid)  w_next_state = RUN;
            RUN:  if (w_last)    w_next_state = DONE;
            DONE: if (out_ready) w_next_state = IDLE;
            default:             w_next_state = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_run     = 1'b0;
        case (r_state)
            IDLE:    in_ready  = 1'b1;
            RUN:     w_run     = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    assign w_accept    = in_valid & in_ready;
    assign w_last      = w_run & (r_cnt == LAST_CNT);
    assign o_dbg_state = r_state;

    // Nibble select and in-place result update, indexed by the counter.
    always_comb begin
        w_a_nib       = '0;
        w_b_nib       = '0;
        w_result_next = r_result;
        for (int n = 0; n < NIB; n++) begin
            if (r_cnt == CNT_W'(n)) begin
                w_a_nib = r_a[n*NIBBLE_W +: NIBBLE_W];
                w_b_nib = r_b[n*NIBBLE_W +: NIBBLE_W];
                w_result_next[n*NIBBLE_W +: NIBBLE_W] = w_sum;
            end
        end
    end

    cla_4bit u_cla (
        .i_a    (w_a_nib),
        .i_b    (w_b_nib),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
        end else if (w_accept) begin
            // Subtract is A + ~B + 1: invert B here and seed the carry with sub.
            r_a      <= a;
            r_b      <= b ^ {WIDTH{sub}};
            r_carry  <= sub;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_run) begin
            r_result <= w_result_next;
            r_carry  <= w_cout;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_carry_out <= w_cout;
            end
        end
    end

    assign result    = r_result;
    assign carry_out = r_carry_out;

`ifdef NIBBLE_SERIAL_ADDER_FLAGS_EN
    logic r_overflow;
    logic r_zero;
    logic w_overflow_next;

    assign w_overflow_next = (r_a[WIDTH-1] == r_b[WIDTH-1]) & (w_sum[NIBBLE_W-1] != r_a[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else if (w_last) begin
            r_overflow <= w_overflow_next;
            r_zero     <= ~|w_result_next;
        end
    end

    assign overflow = r_overflow;
    assign zero     = r_zero;
`else
    assign overflow = 1'b0;
    assign zero     = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder at WIDTH = 8; outputs sampled on the falling edge.
module tb_nibble_serial_adder;
    import nibble_serial_adder_pkg::*;

    localparam int WIDTH = 8;
`ifdef NIBBLE_SERIAL_ADDER_FLAGS_EN
    localparam logic FLAGS_EN = 1'b1;
`else
    localparam logic FLAGS_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    state_t           dbg_state;

    int total = 0;
    int bad   = 0;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .sub         (sub),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .carry_out   (carry_out),
        .overflow    (overflow),
        .zero        (zero),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_result"},    result,    0);
        chk({tag, "_carry"},     carry_out, 0);
        chk({tag, "_overflow"},  overflow,  0);
        chk({tag, "_zero"},      zero,      0);
    endtask

    // Drive one operation from IDLE (called at a falling edge), check latency and flags;
    // optionally complete the output handshake.
    task automatic run_op(input string tag, input logic [7:0] op_a, input logic [7:0] op_b,
                          input logic op_sub, input logic [7:0] exp_res, input logic exp_c,
                          input logic exp_ovf, input logic exp_zero, input logic handshake);
        chk({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        a        = op_a;
        b        = op_b;
        sub      = op_sub;
        @(negedge clk);
        in_valid = 1'b0;
        a        = 8'h00;
        b        = 8'h00;
        sub      = 1'b0;
        chk({tag, "_lat1_out_valid"}, out_valid, 0);
        chk({tag, "_lat1_in_ready"},  in_ready,  0);
        @(negedge clk);
        chk({tag, "_lat2_out_valid"}, out_valid, 0);
        @(negedge clk);
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_in_ready_done"}, in_ready, 0);
        chk({tag, "_result"},   result,    exp_res);
        chk({tag, "_carry"},    carry_out, exp_c);
        chk({tag, "_overflow"}, overflow,  exp_ovf & FLAGS_EN);
        chk({tag, "_zero"},     zero,      exp_zero & FLAGS_EN);
        if (handshake) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk({tag, "_post_out_valid"}, out_valid, 0);
            chk({tag, "_post_in_ready"},  in_ready,  1);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        sub       = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset_in_ready", in_ready, 1);
        chk("reset_state", dbg_state, IDLE);

        run_op("add_3c_45", 8'h3C, 8'h45, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0, 1'b1);
        run_op("sub_50_50", 8'h50, 8'h50, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);

        // Backpressure: hold DONE while new operands are offered.
        run_op("bp_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            a        = 8'h11;
            b        = 8'h22;
            sub      = 1'b0;
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready",  in_ready,  0);
            chk("bp_result",    result,    8'h80);
            chk("bp_carry",     carry_out, 0);
            chk("bp_overflow",  overflow,  FLAGS_EN);
            chk("bp_state",     dbg_state, DONE);
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_out_valid", out_valid, 0);
        chk("bp_release_in_ready",  in_ready,  1);
        chk("bp_release_result",    result,    8'h80);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_next_accepted", in_ready, 0);
        @(negedge clk);
        chk("bp_next_lat2", out_valid, 0);
        @(negedge clk);
        chk("bp_next_out_valid", out_valid, 1);
        chk("bp_next_result",    result,    8'h33);
        chk("bp_next_carry",     carry_out, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_next_post_in_ready", in_ready, 1);

        run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b1);

        // Reset after the first nibble of an in-flight add.
        in_valid = 1'b1;
        a        = 8'hAB;
        b        = 8'h11;
        sub      = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_state_run", dbg_state, RUN);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("mid_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_release_in_ready", in_ready, 1);
        chk_idle_outputs("mid_release");

        run_op("add_12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
